router_fifo: RTL
================

ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of storage entries, power of two.
REQ-002 Parameter WIDTH, default 8, data byte width.
REQ-003 Port clock, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port resetn, input, 1, asynchronous active-low reset.
REQ-005 Port soft_reset, input, 1, synchronous per-FIFO flush from the synchronizer timeout.
REQ-006 Port write_enb, input, 1, write request for this FIFO (one bit of the synchronizer write_enb bus).
REQ-007 Port read_enb, input, 1, read request from the downstream port.
REQ-008 Port lfd_state, input, 1, marks the byte being written as a packet header.
REQ-009 Port data_in, input, WIDTH, byte to store.
REQ-010 Port data_out, output, WIDTH, registered read data.
REQ-011 Port full, output, 1, no free entry.
REQ-012 Port empty, output, 1, no stored entry.
REQ-013 Port pkt_done, output, 1, one-cycle pulse when the last byte (parity) of a packet is read.

Function
REQ-014 Each entry SHALL hold WIDTH+1 bits: {header flag, data byte}; the header flag is lfd_state sampled with the write.
REQ-015 Write and read pointers SHALL be log2(DEPTH)+1 bits; the extra MSB is the wrap bit.
REQ-016 empty SHALL be 1 when the pointers are equal in all bits; full SHALL be 1 when the index bits are equal and the wrap bits differ; both are combinational from the registered pointers.
REQ-017 An accepted write (write_enb=1, full=0) SHALL store the entry at the write index and increment the write pointer, wrapping modulo 2*DEPTH.
REQ-018 write_enb=1 with full=1 SHALL be ignored: no storage change, no pointer change, no error flag.
REQ-019 An accepted read (read_enb=1, empty=0) SHALL load data_out with the stored byte at the read index on the same edge (1-cycle latency) and increment the read pointer.
REQ-020 read_enb=1 with empty=1 SHALL be ignored; data_out holds its value.
REQ-021 Simultaneous write and read SHALL both be evaluated against pre-edge full/empty: when full, only the read completes; when empty, only the write completes; otherwise both complete and occupancy is unchanged.
REQ-022 Packet counter (7 bits): an accepted read of an entry with header flag 1 SHALL load count = data[7:2] + 1 (payload length plus parity).
REQ-023 An accepted read of a non-header entry with count > 0 SHALL decrement count; the decrement from 1 to 0 SHALL assert pkt_done for exactly the following cycle.
REQ-024 A header read while count > 0 (truncated packet) SHALL reload count and SHALL NOT pulse pkt_done; a non-header read with count = 0 SHALL leave count at 0.
REQ-025 soft_reset=1 SHALL, on the clock edge, clear both pointers, count, data_out and pkt_done, and SHALL take priority over write_enb and read_enb in that cycle.
REQ-026 Storage array contents need not be cleared by either reset; they SHALL be unobservable until rewritten.

Reset
REQ-027 resetn=0 SHALL immediately, without a clock edge, clear pointers, count, data_out to 0 and pkt_done to 0, giving empty=1 and full=0.
REQ-028 Release of resetn SHALL take effect at the next rising clock edge; write/read requests during reset SHALL be ignored.
REQ-029 Reset asserted mid-packet SHALL discard all stored entries and the partial count.

Verification
REQ-030 Reset then write header 0x0C (lfd=1), payload 0xA1,0xA2,0xA3, parity 0x55; read 5 -> data_out 0x0C,0xA1,0xA2,0xA3,0x55; pkt_done high only the cycle after 0x55 read; empty=1.
REQ-031 Write 16 bytes -> full=1 after 16th; 17th write ignored; 16 reads return the first 16 bytes in order, then empty=1.
REQ-032 Full FIFO, write_enb=1 and read_enb=1 same cycle -> one byte read, write dropped, full=0 next cycle; empty FIFO, both asserted -> write only, empty=0, data_out unchanged.
REQ-033 Write 6 bytes, assert soft_reset with write_enb=1 -> empty=1, data_out=0x00 next cycle, written byte discarded.
REQ-034 Wrap: write 10, read 10, write 16 -> full=1; read 16 returns correct order across index wrap.
REQ-035 Assert resetn=0 between clock edges mid-packet -> empty=1, data_out=0x00, pkt_done=0 before the next edge.

Source files
------------

// File: rtl/router_fifo.sv
// router_fifo: per-port packet FIFO with header-tagged entries and a parity-end pkt_done pulse.
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             pkt_done
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wptr, rptr;
  logic [WIDTH:0] mem [DEPTH];
  logic [WIDTH:0] rd_entry;
  logic [6:0] count;
  logic wr_ok, rd_ok;
  assign empty = wptr == rptr;
  assign full = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign wr_ok = write_enb && !full && !soft_reset;
  assign rd_ok = read_enb && !empty && !soft_reset;
  assign rd_entry = mem[rptr[AW-1:0]];
  always_ff @(posedge clock)
    if (wr_ok) mem[wptr[AW-1:0]] <= {lfd_state, data_in};
  // Header byte carries payload length in [7:2]; count also covers the trailing parity byte.
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      data_out <= '0;
      pkt_done <= 1'b0;
    end else if (soft_reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      data_out <= '0;
      pkt_done <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + (AW+1)'(1);
      pkt_done <= rd_ok && !rd_entry[WIDTH] && count == 7'd1;
      if (rd_ok) begin
        rptr <= rptr + (AW+1)'(1);
        data_out <= rd_entry[WIDTH-1:0];
        count <= rd_entry[WIDTH] ? {1'b0, rd_entry[7:2]} + 7'd1 : (count != 7'd0 ? count - 7'd1 : 7'd0);
      end
    end
endmodule
